// File: rtl/alu_sout_serializer_if.sv
// Handshake and payload bundle between the ALU core and the result serializer.
// The core drives the request side (master); the serializer answers with
// in_ready (slave).
interface alu_sout_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic        in_err;
  logic [5:0]  in_err_code;

  modport master (
    output in_valid,
    output in_result,
    output in_flags,
    output in_err,
    output in_err_code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_result,
    input  in_flags,
    input  in_err,
    input  in_err_code,
    output in_ready
  );
endinterface

// File: rtl/alu_sout_serializer.sv
// Transmit side of the ALU serial result link.
// Accepts one result word (plus flags) or one error code per handshake and
// shifts it out on sout as 11-bit frames {start=0, ctl, data[7:0], stop=1},
// MSB first, one bit per clk. A result packet is four data frames followed by
// a control frame carrying {0, flags, crc}; an error packet is one control
// frame carrying {1, err_code, even parity}.
// Optional build macro ALU_SOUT_CRC_FAULT_EN adds input crc_fault_inj, which
// (sampled at accept) flips crc[0] of a result packet's control frame.
module alu_sout_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu_sout_serializer_if.slave        bus,
`ifdef ALU_SOUT_CRC_FAULT_EN
  input  logic                        crc_fault_inj,
`endif
  output logic                        sout,
  output logic                        busy,
  output logic                        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] LAST_BIT   = 4'd10;
  localparam logic [2:0] LAST_FRAME = 3'd4;
  localparam logic [3:0] GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  bit_cnt;
  logic [2:0]  frame_cnt;
  logic [3:0]  gap_cnt;

  logic [31:0] res_q;
  logic [3:0]  flags_q;
  logic        err_q;
  logic [5:0]  code_q;
`ifdef ALU_SOUT_CRC_FAULT_EN
  logic        fault_q;
`endif

  logic        sout_q;
  logic        busy_q;
  logic        done_q;
  logic        ready_q;

  logic [2:0]  crc_val;
  logic [2:0]  crc_out;
  logic        err_parity;
  logic        frame_ctl;
  logic [7:0]  frame_data;
  logic [10:0] cur_frame;
  logic        last_frame;

  // Serial x^3+x+1 CRC, zero seed, highest bit of the vector fed in first.
  function automatic logic [2:0] crc3(input logic [36:0] vec);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = vec[i] ^ c[2];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // CRC and parity are derived from the registered packet, so they are stable
  // for the whole packet regardless of what the core does with its inputs.
  always_comb begin
    crc_val    = crc3({res_q, 1'b0, flags_q});
`ifdef ALU_SOUT_CRC_FAULT_EN
    crc_out    = crc_val ^ {2'b00, fault_q};
`else
    crc_out    = crc_val;
`endif
    err_parity = ^{1'b1, code_q};
  end

  // Build the frame currently selected by the frame counter.
  always_comb begin
    frame_ctl  = 1'b0;
    frame_data = 8'h00;
    if (err_q) begin
      frame_ctl  = 1'b1;
      frame_data = {1'b1, code_q, err_parity};
    end else begin
      case (frame_cnt)
        3'd0:    frame_data = res_q[31:24];
        3'd1:    frame_data = res_q[23:16];
        3'd2:    frame_data = res_q[15:8];
        3'd3:    frame_data = res_q[7:0];
        3'd4: begin
          frame_ctl  = 1'b1;
          frame_data = {1'b0, flags_q, crc_out};
        end
        default: frame_data = 8'h00;
      endcase
    end
    cur_frame  = {1'b0, frame_ctl, frame_data, 1'b1};
    last_frame = err_q | (frame_cnt == LAST_FRAME);
  end

  // Packet sequencer: accept in IDLE, shift bits, optionally idle-high between
  // frames, then pulse done on the first IDLE cycle after the last stop bit.
  // sout is registered; the start bit is loaded directly on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      frame_cnt <= 3'd0;
      gap_cnt   <= 4'd0;
      res_q     <= 32'd0;
      flags_q   <= 4'd0;
      err_q     <= 1'b0;
      code_q    <= 6'd0;
`ifdef ALU_SOUT_CRC_FAULT_EN
      fault_q   <= 1'b0;
`endif
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.in_valid && ready_q) begin
            res_q     <= bus.in_result;
            flags_q   <= bus.in_flags;
            err_q     <= bus.in_err;
            code_q    <= bus.in_err_code;
`ifdef ALU_SOUT_CRC_FAULT_EN
            fault_q   <= crc_fault_inj;
`endif
            state     <= SHIFT;
            bit_cnt   <= 4'd0;
            frame_cnt <= 3'd0;
            gap_cnt   <= 4'd0;
            sout_q    <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_cnt + 4'd1;
            sout_q  <= cur_frame[4'd9 - bit_cnt];
          end else if (last_frame) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            frame_cnt <= 3'd0;
            sout_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state     <= GAP;
            bit_cnt   <= 4'd0;
            gap_cnt   <= 4'd0;
            frame_cnt <= frame_cnt + 3'd1;
            sout_q    <= 1'b1;
          end else begin
            bit_cnt   <= 4'd0;
            frame_cnt <= frame_cnt + 3'd1;
            sout_q    <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= SHIFT;
            gap_cnt <= 4'd0;
            sout_q  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sout         = sout_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.in_ready = ready_q;

endmodule

// File: doc/alu_sout_serializer.md
Name: alu_sout_serializer

Overview:
- Transmit side of the ALU serial result link.
- Accepts one ALU result word, with flags or an error code, through a valid/ready handshake.
- Builds the 11-bit frames, computes the 3-bit output CRC and shifts the frames onto `sout` MSB-first, one bit per `clk`.
- Sits at the ALU core output; its `sout` is the line the testbench result deserializer samples on `posedge clk`.

Parameters:
- GAP_CYCLES, 0, idle-high cycles inserted between consecutive frames of one packet (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request to send one packet
- in_ready  out  1  block can accept a packet
- in_result  in  32  ALU result C
- in_flags  in  4  ALU flags {carry, overflow, zero, negative}
- in_err  in  1  1 = send error packet instead of result packet
- in_err_code  in  6  error flags, used when in_err=1
- sout  out  1  serial output line, idle high
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse when a packet has completed

Behaviour:
- Reset (rst_n=0 at posedge clk) forces the following values on that edge:
  - sout=1, in_ready=0, busy=0, done=0.
  - state=IDLE, all counters 0.
  - in_ready rises the cycle after rst_n=1 is sampled.
- Reset mid-frame aborts the packet immediately:
  - sout returns high.
  - no done pulse; no partial frame resumes.
- Frame format, 11 bits sent MSB-first: {start=0, ctl, data[7:0], stop=1}. ctl=0 for data frames, 1 for control frames.
- Result packet (in_err=0), 5 frames:
  - Data frames carry in_result[31:24], [23:16], [15:8], [7:0] in that order.
  - The control frame follows with data = {1'b0, in_flags[3:0], crc[2:0]}.
- CRC:
  - Polynomial x^3+x+1, initial value 000.
  - Computed over the 37-bit vector {in_result, 1'b0, in_flags}, bit 36 processed first.
  - Computed combinationally from registered copies at accept.
- Error packet (in_err=1): a single control frame with data = {1'b1, in_err_code[5:0], p}. p is even parity over {1'b1, in_err_code}.
- Handshake:
  - in_ready=1 only in IDLE.
  - Transfer when in_valid & in_ready at posedge clk; all inputs are registered on that edge.
  - Inputs are ignored while busy.
- States and transitions:
  - IDLE → SHIFT on accept.
  - SHIFT → GAP after bit 10 when more frames remain and GAP_CYCLES>0.
  - SHIFT → SHIFT (next frame) when more frames remain and GAP_CYCLES=0.
  - SHIFT → IDLE after the last frame's stop bit.
  - GAP → SHIFT after GAP_CYCLES cycles.
- Timing:
  - The start bit appears on sout in the cycle after accept; each bit lasts exactly one clk.
  - Result packet length: 55 + 4*GAP_CYCLES cycles. Error packet length: 11 cycles.
- busy=1 from the cycle after accept through the last stop bit.
- done=1 for exactly one cycle, the first IDLE cycle after the packet.
  - in_ready is also 1 in that cycle, so back-to-back packets are legal: accept on the done edge and the next start bit follows immediately.
- Counters:
  - bit counter 0..10 and frame counter 0..4, no wrap beyond the terminal value.
  - gap counter counts 0..GAP_CYCLES-1.
- sout=1 in IDLE and GAP; the line is never low for more than one frame's payload.

Optional Feature:
- Macro: ALU_SOUT_CRC_FAULT_EN.
- Defined:
  - Adds input port `crc_fault_inj` (1 bit), sampled at accept.
  - When it is 1, crc[0] is inverted in the control frame of a result packet, for monitor/scoreboard negative tests.
  - It has no effect on error packets.
- Undefined: the port does not exist and the CRC is always correct.

Test Plan:
- Reset-mid-frame: assert rst_n=0 during frame 2 bit 5 → sout=1, busy=0 on the next edge; no done; next packet is sent cleanly.
- in_result=0, in_flags=0, GAP_CYCLES=0 → frames 0x001 ×4 (binary 0_0_00000000_1), then control 0_1_00000000_1; done at cycle 56 after accept.
- in_result=0x12345678, in_flags=4'b0010 → data bytes 0x12, 0x34, 0x56, 0x78; control data = {0, 0010, crc}, crc matching the golden x^3+x+1 model.
- in_err=1, in_err_code=6'b100100 → single frame 0_1_11001001_1 (data 0xC9); done 12 cycles after accept.
- Back-to-back: in_valid held high with two packets → second start bit in the cycle after the first done; no idle-high cycle lost or added.
- GAP_CYCLES=3: → exactly 3 high cycles between frames; total 67 cycles; in_valid pulses during busy are ignored and in_ready stays 0.
